wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
Synthesizable commit-trace capture stage that sits directly downstream of the CPU writeback stage in openmips_min_sopc. Every architectural register write is recorded as an entry holding the destination register, the write data and a cycle stamp. Entries are queued in a show-ahead FIFO and drained through a valid/ready port by the self-checking bench or a debug UART. Back-pressure from the consumer never stalls the CPU: when the FIFO is full, new entries are dropped and counted.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CYCLE_W, 32, width of the free-running cycle counter and of the entry stamp.
DROP_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
wb_wreg_i  in  1  writeback register write enable
wb_wd_i  in  5  writeback destination register index
wb_wdata_i  in  32  writeback data
clear_i  in  1  synchronous flush of the FIFO and error state
trace_valid_o  out  1  head entry is available
trace_ready_i  in  1  consumer accepts the head entry
trace_wd_o  out  5  head entry register index
trace_wdata_o  out  32  head entry data
trace_cycle_o  out  CYCLE_W  head entry cycle stamp
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky flag: at least one entry was dropped
drop_cnt_o  out  DROP_W  number of dropped entries, saturating

Behaviour:
- Reset (asynchronous, active-high) clears the read pointer, write pointer, count, cycle counter, overflow flag and drop counter. All outputs read 0 while rst is high, including trace_valid_o.
- Cycle counter: reads 0 in the first cycle after reset release and increments on every rising edge. It wraps modulo 2^CYCLE_W. clear_i does not affect it.
- Capture condition: wb_wreg_i && (wb_wd_i != 0). Writes to $0 are never recorded.
- An entry is written on the rising edge at the end of the capture cycle. Its stamp is the counter value during that cycle.
- Latency: trace_valid_o and the head fields become valid one cycle after the capture cycle.
- Pop: a pop occurs on the rising edge when trace_valid_o && trace_ready_i. trace_ready_i is ignored while the FIFO is empty.
- Show-ahead head: trace_* outputs are driven from the entry at the read pointer. They stay stable while valid && !ready.
- Pointers wrap modulo DEPTH. count_o = number of stored entries, range 0..DEPTH.
- Full, no pop in the same cycle: the capture is dropped, overflow_o is set (sticky), and drop_cnt_o increments, saturating at all-ones.
- Full, pop in the same cycle: the capture is accepted and count_o stays at DEPTH.
- Empty with a capture: no bypass. trace_valid_o rises on the next cycle.
- Push and pop in the same cycle with 0 < count < DEPTH: count_o is unchanged.
- clear_i (synchronous, highest priority after reset) zeroes the pointers, count, overflow_o and drop_cnt_o. Any capture or pop in the same cycle is discarded.
- Reset asserted mid-stream discards all entries immediately. No partial entry survives.

Decomposition:
- Shared package trace_pkg holds:
  - the trace_entry_t packed struct {wd[4:0], wdata[31:0], cycle[CYCLE_W-1:0]};
  - the constants TRACE_WD_W=5 and TRACE_DATA_W=32;
  - the function is_trace_capture(wreg, wd).
- One sub-module, trace_fifo: a generic show-ahead synchronous FIFO parameterised on DEPTH and the entry type. It provides push, pop, clear, full, empty and count.
- The top level (wb_trace_buffer) owns the cycle counter, the capture qualification and the overflow/drop logic.

Test Plan:
1. Release reset, then drive wreg=1, wd=1, wdata=0x00001100 in the first cycle -> next cycle: valid=1, wd=1, wdata=0x00001100, cycle=0, count=1.
2. Drive wreg=1, wd=0, wdata=0xDEADBEEF, and separately wreg=0, wd=3 -> valid stays 0, count stays 0.
3. Hold trace_ready_i=0 and issue 20 captures with wdata=0..19 -> count=16, overflow_o=1, drop_cnt_o=4. Then drain with ready=1 -> wdata 0..15 appear in order, and valid drops after the 16th pop.
4. With the FIFO full and ready=1, capture wdata=0xA5A5A5A5 -> count stays 16, drop_cnt unchanged, and the new entry is the last one drained.
5. With 5 entries queued, pulse clear_i together with a capture -> next cycle: count=0, valid=0, overflow=0, drop_cnt=0; the cycle stamp continues incrementing.
6. With 3 entries queued, assert rst asynchronously mid-cycle -> all outputs read 0 immediately. After release, the first capture is stamped cycle=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and helpers for the writeback commit-trace capture path.
package trace_pkg;

    localparam int TRACE_WD_W    = 5;
    localparam int TRACE_DATA_W  = 32;
    localparam int TRACE_CYCLE_W = 32;

    typedef struct packed {
        logic [TRACE_WD_W-1:0]    wd;
        logic [TRACE_DATA_W-1:0]  wdata;
        logic [TRACE_CYCLE_W-1:0] cycle;
    } trace_entry_t;

    // $0 is hard-wired to zero, so writes to it carry no architectural state.
    function automatic logic is_trace_capture(input logic wreg, input logic [TRACE_WD_W-1:0] wd);
        return wreg && (wd != '0);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO; dout always presents the entry at the read pointer.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (!do_push && do_pop) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture behind the writeback stage: stamps register writes, queues them, counts drops.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 32,
    parameter int DROP_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_wreg_i,
    input  logic [TRACE_WD_W-1:0]     wb_wd_i,
    input  logic [TRACE_DATA_W-1:0]   wb_wdata_i,
    input  logic                      clear_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [TRACE_WD_W-1:0]     trace_wd_o,
    output logic [TRACE_DATA_W-1:0]   trace_wdata_o,
    output logic [CYCLE_W-1:0]        trace_cycle_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [DROP_W-1:0]         drop_cnt_o
);

    typedef struct packed {
        logic [TRACE_WD_W-1:0]   wd;
        logic [TRACE_DATA_W-1:0] wdata;
        logic [CYCLE_W-1:0]      cycle;
    } entry_t;

    logic [CYCLE_W-1:0] cycle_q;
    logic               cap;
    logic               pop;
    logic               full;
    logic               empty;
    entry_t             din;
    entry_t             head;

    assign cap = is_trace_capture(wb_wreg_i, wb_wd_i);
    assign pop = trace_valid_o && trace_ready_i;
    assign din = '{wd: wb_wd_i, wdata: wb_wdata_i, cycle: cycle_q};

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_i),
        .push  (cap),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count_o)
    );

    // Head fields are masked while empty so stale RAM never leaks out (and reads 0 in reset).
    assign trace_valid_o = !empty;
    assign trace_wd_o    = trace_valid_o ? head.wd    : '0;
    assign trace_wdata_o = trace_valid_o ? head.wdata : '0;
    assign trace_cycle_o = trace_valid_o ? head.cycle : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + CYCLE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (cap && full && !pop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: capture, filter, overflow, full+pop, clear and async reset.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_wreg_i = 1'b0;
    logic [4:0]  wb_wd_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic        clear_i = 1'b0;
    logic        trace_valid_o;
    logic        trace_ready_i = 1'b0;
    logic [4:0]  trace_wd_o;
    logic [31:0] trace_wdata_o;
    logic [31:0] trace_cycle_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] mcyc;
    logic [31:0] exp_cyc;

    wb_trace_buffer #(.DEPTH(16), .CYCLE_W(32), .DROP_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_wreg_i     (wb_wreg_i),
        .wb_wd_i       (wb_wd_i),
        .wb_wdata_i    (wb_wdata_i),
        .clear_i       (clear_i),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_wd_o    (trace_wd_o),
        .trace_wdata_o (trace_wdata_o),
        .trace_cycle_o (trace_cycle_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: reset with the DUT, counts every rising edge otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) mcyc <= '0;
        else     mcyc <= mcyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [4:0] wd, input logic [31:0] data);
        wb_wreg_i  = 1'b1;
        wb_wd_i    = wd;
        wb_wdata_i = data;
    endtask

    task automatic idle();
        wb_wreg_i  = 1'b0;
        wb_wd_i    = '0;
        wb_wdata_i = '0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        step();
        rst = 1'b0;

        // 1: first capture after reset is stamped 0
        cap(5'd1, 32'h0000_1100);
        step();
        idle();
        chk("t1_valid", 64'(trace_valid_o), 64'd1);
        chk("t1_wd", 64'(trace_wd_o), 64'd1);
        chk("t1_wdata", 64'(trace_wdata_o), 64'h1100);
        chk("t1_cycle", 64'(trace_cycle_o), 64'd0);
        chk("t1_count", 64'(count_o), 64'd1);
        trace_ready_i = 1'b1;
        step();
        trace_ready_i = 1'b0;
        chk("t1_popped", 64'(count_o), 64'd0);

        // 2: $0 writes and disabled writes are filtered
        cap(5'd0, 32'hDEAD_BEEF);
        step();
        chk("t2_wd0_valid", 64'(trace_valid_o), 64'd0);
        chk("t2_wd0_count", 64'(count_o), 64'd0);
        wb_wreg_i = 1'b0; wb_wd_i = 5'd3;
        step();
        idle();
        chk("t2_nowreg_valid", 64'(trace_valid_o), 64'd0);
        chk("t2_nowreg_count", 64'(count_o), 64'd0);

        // 3: overflow with ready low, then in-order drain
        for (int i = 0; i < 20; i++) begin
            cap(5'(i % 31 + 1), 32'(i));
            step();
        end
        idle();
        chk("t3_count", 64'(count_o), 64'd16);
        chk("t3_ovf", 64'(overflow_o), 64'd1);
        chk("t3_drop", 64'(drop_cnt_o), 64'd4);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_drain_v%0d", i), 64'(trace_valid_o), 64'd1);
            chk($sformatf("t3_drain_d%0d", i), 64'(trace_wdata_o), 64'(i));
            step();
        end
        trace_ready_i = 1'b0;
        chk("t3_empty_valid", 64'(trace_valid_o), 64'd0);
        chk("t3_empty_count", 64'(count_o), 64'd0);

        // 4: full FIFO accepts a capture when a pop happens on the same edge
        for (int i = 0; i < 16; i++) begin
            cap(5'd7, 32'h100 + 32'(i));
            step();
        end
        chk("t4_full", 64'(count_o), 64'd16);
        chk("t4_hold_d", 64'(trace_wdata_o), 64'h100);
        step();
        chk("t4_stable_d", 64'(trace_wdata_o), 64'h100);
        chk("t4_drop_full", 64'(drop_cnt_o), 64'd5);
        cap(5'd9, 32'hA5A5_A5A5);
        trace_ready_i = 1'b1;
        step();
        idle();
        chk("t4_count", 64'(count_o), 64'd16);
        chk("t4_drop", 64'(drop_cnt_o), 64'd5);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_drain_d%0d", i), 64'(trace_wdata_o),
                (i == 15) ? 64'hA5A5_A5A5 : 64'h101 + 64'(i));
            step();
        end
        trace_ready_i = 1'b0;
        chk("t4_empty", 64'(trace_valid_o), 64'd0);

        // 5: clear wins over a same-cycle capture; cycle counter keeps running
        for (int i = 0; i < 5; i++) begin
            cap(5'd2, 32'h200 + 32'(i));
            step();
        end
        chk("t5_pre_count", 64'(count_o), 64'd5);
        cap(5'd4, 32'h0BAD_0BAD);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        idle();
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_valid", 64'(trace_valid_o), 64'd0);
        chk("t5_ovf", 64'(overflow_o), 64'd0);
        chk("t5_drop", 64'(drop_cnt_o), 64'd0);
        exp_cyc = mcyc;
        cap(5'd5, 32'h0000_0555);
        step();
        idle();
        chk("t5_cycle", 64'(trace_cycle_o), 64'(exp_cyc));
        chk("t5_cycle_nz", 64'(trace_cycle_o > 32'd60), 64'd1);

        // 6: async reset mid-cycle discards everything immediately
        cap(5'd6, 32'h600);
        step();
        cap(5'd6, 32'h601);
        step();
        idle();
        chk("t6_pre_count", 64'(count_o), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(trace_valid_o), 64'd0);
        chk("t6_rst_count", 64'(count_o), 64'd0);
        chk("t6_rst_wdata", 64'(trace_wdata_o), 64'd0);
        chk("t6_rst_cycle", 64'(trace_cycle_o), 64'd0);
        chk("t6_rst_wd", 64'(trace_wd_o), 64'd0);
        step();
        rst = 1'b0;
        cap(5'd8, 32'h0000_0888);
        step();
        idle();
        chk("t6_post_valid", 64'(trace_valid_o), 64'd1);
        chk("t6_post_cycle", 64'(trace_cycle_o), 64'd0);
        chk("t6_post_wdata", 64'(trace_wdata_o), 64'h888);
        chk("t6_post_count", 64'(count_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
